// File: rtl/inc_share_ctrl.sv
// Round-robin sequencer that time-shares one external ripple incrementer among
// N_REQ requesters and returns each sum/carry on a tagged valid/ready channel.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a request; inc_a holds the last operand
// SETTLE   | operand driven, counting down the ripple settle time
// RESP     | result captured, holding response until rsp_ready
module inc_share_ctrl #(
   parameter int N_REQ  = 4,
   parameter int WIDTH  = 16,
   parameter int SETTLE = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [N_REQ*WIDTH-1:0]   req_data,
   output logic [N_REQ-1:0]         req_ready,
   output logic [WIDTH-1:0]         inc_a,
   input  logic [WIDTH-1:0]         inc_s,
   input  logic                     inc_cout,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [$clog2(N_REQ)-1:0] rsp_id,
   output logic [WIDTH-1:0]         rsp_data,
   output logic                     rsp_ovf,
   output logic                     busy
);

   localparam int ID_W  = $clog2(N_REQ);
   localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   logic [1:0]       state;
   logic [ID_W-1:0]  rr_ptr;
   logic [CNT_W-1:0] cnt;
   logic             grant_found;
   logic [ID_W-1:0]  grant_idx;
   logic [ID_W-1:0]  cand;

   // base and off are both below N_REQ, so one subtraction completes the wrap
   function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= N_REQ) s = s - N_REQ;
      return s[ID_W-1:0];
   endfunction

   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = wrap_idx(rr_ptr, k);
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   // Strobe is gated by rst_n so it is quiet while reset is held
   always_comb begin
      req_ready = '0;
      if (rst_n && state == ST_IDLE && grant_found)
         req_ready[grant_idx] = 1'b1;
   end

   assign busy = (state != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         rr_ptr    <= '0;
         cnt       <= '0;
         inc_a     <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
         rsp_ovf   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant_found) begin
                  inc_a  <= req_data[int'(grant_idx)*WIDTH +: WIDTH];
                  rsp_id <= grant_idx;
                  cnt    <= CNT_W'(SETTLE - 1);
                  rr_ptr <= wrap_idx(grant_idx, 1);
                  state  <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end else begin
                  rsp_data  <= inc_s;
                  rsp_ovf   <= inc_cout;
                  rsp_valid <= 1'b1;
                  state     <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
